decode_ctrl_pipe: RTL and testbench

DECODE_CTRL_PIPE -- requirements
Module: decode_ctrl_pipe

---
 rtl/decode_ctrl_pipe.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_decode_ctrl_pipe.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode_ctrl_pipe.sv
// -----------------------------------------------------------------------------
// decode_ctrl_pipe
//
// Decodes a MIPS instruction word in ID and registers the resulting control
// bundle into the EX stage one cycle later. A small HI/LO busy counter holds
// back MFHI/MFLO/MULT/MULTU while a multiply is still in flight.
//
// Optional feature: define GPIO_EN to reinterpret zero-shift SRL as a GPIO
// write strobe and zero-shift SRA as a GPIO read strobe. Without it those
// encodings are ordinary shifts and both GPIO strobes are tied low.
//
// Parameters
//   MULT_LAT  cycles HI/LO stay busy after MULT/MULTU enters EX (0..15,
//             0 disables the interlock)
//   SHAMT_W   width of shamt_EX
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   instr_valid     instruction_ID holds a real instruction
//   instruction_ID  MIPS word: opcode [31:26], shamt [10:6], funct [5:0]
//   stall_in        downstream stall, EX registers hold
//   flush           squash the instruction being decoded
//   stall_FETCH     fetch/ID must hold the current instruction
//   valid_EX .. illegal_EX  registered EX control bundle
//
// Handshake: an ID instruction is consumed on a rising edge exactly when
// stall_FETCH is low (or when flush squashes it); while stall_FETCH is high
// the upstream stage must present the same instruction again.
// -----------------------------------------------------------------------------
module decode_ctrl_pipe #(
  parameter int MULT_LAT = 4,
  parameter int SHAMT_W  = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  input  logic [31:0]        instruction_ID,
  input  logic               stall_in,
  input  logic               flush,
  output logic               stall_FETCH,
  output logic               valid_EX,
  output logic [3:0]         alu_op,
  output logic [SHAMT_W-1:0] shamt_EX,
  output logic               enhilo_EX,
  output logic [1:0]         regsel_EX,
  output logic               regwrite_EX,
  output logic               rdrt_EX,
  output logic               memwrite_EX,
  output logic [1:0]         alu_src_EX,
  output logic               gpio_out_EX,
  output logic               gpio_in_EX,
  output logic               illegal_EX
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  localparam logic [3:0] BUSY_LOAD = 4'(MULT_LAT);

  typedef struct packed {
    logic               valid;
    logic [3:0]         alu_op;
    logic [SHAMT_W-1:0] shamt;
    logic               enhilo;
    logic [1:0]         regsel;
    logic               regwrite;
    logic               rdrt;
    logic               memwrite;
    logic [1:0]         alu_src;
    logic               gpio_out;
    logic               gpio_in;
    logic               illegal;
  } ex_bundle_t;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] shamt_id;
  logic       unused_fields;

  assign opcode        = instruction_ID[31:26];
  assign funct         = instruction_ID[5:0];
  assign shamt_id      = instruction_ID[10:6];
  assign unused_fields = ^instruction_ID[25:11];

  ex_bundle_t dec;
  ex_bundle_t ex_r;
  logic       dec_mult;
  logic       dec_hilo;
  logic [3:0] busy_cnt;
  logic       interlock;
  logic       load_ex;

  // ---------------------------------------------------------------------------
  // Instruction decode. Every field starts at zero so unused fields never
  // carry X; anything not matched falls through to an illegal bubble.
  // ---------------------------------------------------------------------------
  always_comb begin
    dec      = '0;
    dec_mult = 1'b0;
    dec_hilo = 1'b0;
    if (instruction_ID == 32'd0) begin
      // Canonical NOP: live slot that writes nothing.
      dec.valid = 1'b1;
    end else begin
      case (opcode)
        OP_RTYPE: begin
          dec.valid = 1'b1;
          case (funct)
            F_ADD, F_ADDU: begin dec.alu_op = 4'b0100; dec.regwrite = 1'b1; end
            F_SUB, F_SUBU: begin dec.alu_op = 4'b0101; dec.regwrite = 1'b1; end
            F_AND:         begin dec.alu_op = 4'b0000; dec.regwrite = 1'b1; end
            F_OR:          begin dec.alu_op = 4'b0001; dec.regwrite = 1'b1; end
            F_NOR:         begin dec.alu_op = 4'b0010; dec.regwrite = 1'b1; end
            F_XOR:         begin dec.alu_op = 4'b0011; dec.regwrite = 1'b1; end
            F_SLT:         begin dec.alu_op = 4'b1100; dec.regwrite = 1'b1; end
            F_SLTU:        begin dec.alu_op = 4'b1101; dec.regwrite = 1'b1; end
            F_SLL: begin
              dec.alu_op   = 4'b1000;
              dec.shamt    = SHAMT_W'(shamt_id);
              dec.regwrite = 1'b1;
            end
            F_SRL: begin
`ifdef GPIO_EN
              if (shamt_id == 5'd0) begin
                dec.gpio_out = 1'b1;
              end else begin
                dec.alu_op   = 4'b1001;
                dec.shamt    = SHAMT_W'(shamt_id);
                dec.regwrite = 1'b1;
              end
`else
              dec.alu_op   = 4'b1001;
              dec.shamt    = SHAMT_W'(shamt_id);
              dec.regwrite = 1'b1;
`endif
            end
            F_SRA: begin
`ifdef GPIO_EN
              if (shamt_id == 5'd0) begin
                dec.gpio_in  = 1'b1;
                dec.regwrite = 1'b1;
              end else begin
                dec.alu_op   = 4'b1010;
                dec.shamt    = SHAMT_W'(shamt_id);
                dec.regwrite = 1'b1;
              end
`else
              dec.alu_op   = 4'b1010;
              dec.shamt    = SHAMT_W'(shamt_id);
              dec.regwrite = 1'b1;
`endif
            end
            F_MULT: begin
              dec.alu_op = 4'b0110;
              dec.enhilo = 1'b1;
              dec_mult   = 1'b1;
              dec_hilo   = 1'b1;
            end
            F_MULTU: begin
              dec.alu_op = 4'b0111;
              dec.enhilo = 1'b1;
              dec_mult   = 1'b1;
              dec_hilo   = 1'b1;
            end
            F_MFHI: begin
              dec.regsel   = 2'd1;
              dec.regwrite = 1'b1;
              dec_hilo     = 1'b1;
            end
            F_MFLO: begin
              dec.regsel   = 2'd2;
              dec.regwrite = 1'b1;
              dec_hilo     = 1'b1;
            end
            default: begin
              dec.valid   = 1'b0;
              dec.illegal = 1'b1;
            end
          endcase
        end
        OP_ADDI, OP_ADDIU: begin
          dec.valid = 1'b1; dec.alu_op = 4'b0100; dec.regwrite = 1'b1;
          dec.rdrt  = 1'b1; dec.alu_src = 2'd1;
        end
        OP_SLTI: begin
          dec.valid = 1'b1; dec.alu_op = 4'b1100; dec.regwrite = 1'b1;
          dec.rdrt  = 1'b1; dec.alu_src = 2'd1;
        end
        OP_ANDI: begin
          dec.valid = 1'b1; dec.alu_op = 4'b0000; dec.regwrite = 1'b1;
          dec.rdrt  = 1'b1; dec.alu_src = 2'd2;
        end
        OP_ORI: begin
          dec.valid = 1'b1; dec.alu_op = 4'b0001; dec.regwrite = 1'b1;
          dec.rdrt  = 1'b1; dec.alu_src = 2'd2;
        end
        OP_XORI: begin
          dec.valid = 1'b1; dec.alu_op = 4'b0011; dec.regwrite = 1'b1;
          dec.rdrt  = 1'b1; dec.alu_src = 2'd2;
        end
        OP_LUI: begin
          // Implemented as immediate << 16 through the shifter.
          dec.valid = 1'b1; dec.alu_op = 4'b1000; dec.regwrite = 1'b1;
          dec.rdrt  = 1'b1; dec.alu_src = 2'd1;
          dec.shamt = SHAMT_W'(16);
        end
        OP_LW: begin
          dec.valid = 1'b1; dec.alu_op = 4'b0100; dec.regwrite = 1'b1;
          dec.rdrt  = 1'b1; dec.alu_src = 2'd1; dec.regsel = 2'd3;
        end
        OP_SW: begin
          dec.valid = 1'b1; dec.alu_op = 4'b0100; dec.rdrt = 1'b1;
          dec.alu_src = 2'd1; dec.memwrite = 1'b1;
        end
        default: begin
          dec.illegal = 1'b1;
        end
      endcase
    end
  end

  // Anything touching HI/LO waits until the previous multiply has drained.
  assign interlock   = instr_valid && dec_hilo && (busy_cnt != 4'd0);
  assign stall_FETCH = interlock || stall_in;

  // The decoded instruction is actually written into EX only on this path;
  // busy_cnt keys off the same condition so a flushed, interlocked or
  // stall-held MULT never (re)loads it.
  assign load_ex = !flush && !stall_in && !interlock && instr_valid;

  // ---------------------------------------------------------------------------
  // EX register. Priority: rst > flush > stall_in > interlock > load.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_r <= '0;
    end else if (flush) begin
      ex_r <= '0;
    end else if (stall_in) begin
      // Hold the slot, but an illegal flag is a single-cycle event; the slot
      // is a bubble anyway, so dropping it loses nothing.
      ex_r.illegal <= 1'b0;
    end else if (interlock) begin
      ex_r <= '0;
    end else if (instr_valid) begin
      ex_r <= dec;
    end else begin
      ex_r <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_cnt <= 4'd0;
    end else if (load_ex && dec_mult) begin
      busy_cnt <= BUSY_LOAD;
    end else if (busy_cnt != 4'd0) begin
      busy_cnt <= busy_cnt - 4'd1;
    end
  end

  assign valid_EX    = ex_r.valid;
  assign alu_op      = ex_r.alu_op;
  assign shamt_EX    = ex_r.shamt;
  assign enhilo_EX   = ex_r.enhilo;
  assign regsel_EX   = ex_r.regsel;
  assign regwrite_EX = ex_r.regwrite;
  assign rdrt_EX     = ex_r.rdrt;
  assign memwrite_EX = ex_r.memwrite;
  assign alu_src_EX  = ex_r.alu_src;
  assign gpio_out_EX = ex_r.gpio_out;
  assign gpio_in_EX  = ex_r.gpio_in;
  assign illegal_EX  = ex_r.illegal;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// -----------------------------------------------------------------------------
// tb_decode_ctrl_pipe
//
// Directed bench for decode_ctrl_pipe (default MULT_LAT=4, SHAMT_W=5).
// The driver applies one ID-stage vector per cycle just after the rising
// edge and queues the hand-computed EX bundle expected after the following
// edge plus the stall_FETCH value expected during the current cycle. The
// monitor checks on the falling edge. Define GPIO_EN for both DUT and bench
// to exercise the GPIO decode.
// -----------------------------------------------------------------------------
module tb_decode_ctrl_pipe;

  localparam int W = 21;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instruction_ID;
  logic        stall_in;
  logic        flush;
  logic        stall_FETCH;
  logic        valid_EX;
  logic [3:0]  alu_op;
  logic [4:0]  shamt_EX;
  logic        enhilo_EX;
  logic [1:0]  regsel_EX;
  logic        regwrite_EX;
  logic        rdrt_EX;
  logic        memwrite_EX;
  logic [1:0]  alu_src_EX;
  logic        gpio_out_EX;
  logic        gpio_in_EX;
  logic        illegal_EX;

  decode_ctrl_pipe #(.MULT_LAT(4), .SHAMT_W(5)) dut (
    .clk            (clk),
    .rst            (rst),
    .instr_valid    (instr_valid),
    .instruction_ID (instruction_ID),
    .stall_in       (stall_in),
    .flush          (flush),
    .stall_FETCH    (stall_FETCH),
    .valid_EX       (valid_EX),
    .alu_op         (alu_op),
    .shamt_EX       (shamt_EX),
    .enhilo_EX      (enhilo_EX),
    .regsel_EX      (regsel_EX),
    .regwrite_EX    (regwrite_EX),
    .rdrt_EX        (rdrt_EX),
    .memwrite_EX    (memwrite_EX),
    .alu_src_EX     (alu_src_EX),
    .gpio_out_EX    (gpio_out_EX),
    .gpio_in_EX     (gpio_in_EX),
    .illegal_EX     (illegal_EX)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  logic         stall_q[$];
  string        cur_name;
  int           total;
  int           bad;

  function automatic logic [W-1:0] mk(
    input logic v, input logic [3:0] op, input logic [4:0] sh,
    input logic hl, input logic [1:0] rs, input logic rw, input logic rd,
    input logic mw, input logic [1:0] src, input logic go, input logic gi,
    input logic il);
    return {v, op, sh, hl, rs, rw, rd, mw, src, go, gi, il};
  endfunction

  // ---------------- driver ----------------
  task automatic step(input string nm, input logic r, input logic v,
                      input logic [31:0] ins, input logic st, input logic fl,
                      input logic [W-1:0] e, input logic es);
    @(posedge clk);
    #1;
    rst            = r;
    instr_valid    = v;
    instruction_ID = ins;
    stall_in       = st;
    flush          = fl;
    cur_name       = nm;
    exp_q.push_back(e);
    name_q.push_back(nm);
    stall_q.push_back(es);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] act;
    logic [W-1:0] e;
    logic         es;
    string        nm;
    if (stall_q.size() > 0) begin
      es = stall_q.pop_front();
      total++;
      if (stall_FETCH !== es) begin
        bad++;
        $display("FAIL stall_fetch[%s]: got %b expected %b", cur_name, stall_FETCH, es);
      end
    end
    // The entry pushed in the previous cycle is the one now visible in EX.
    if (exp_q.size() >= 2) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      act = {valid_EX, alu_op, shamt_EX, enhilo_EX, regsel_EX, regwrite_EX,
             rdrt_EX, memwrite_EX, alu_src_EX, gpio_out_EX, gpio_in_EX,
             illegal_EX};
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL ex_bundle[%s]: got %h expected %h", nm, act, e);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] bub, nop, e_add, e_ori, e_sll, e_lui, e_lw, e_sw, e_sub;
    logic [W-1:0] e_slt, e_srl0, e_sra0, e_ill, e_mult, e_multu, e_mfhi, e_mflo;
    total = 0;
    bad   = 0;
    cur_name       = "init";
    rst            = 1'b1;
    instr_valid    = 1'b0;
    instruction_ID = 32'd0;
    stall_in       = 1'b0;
    flush          = 1'b0;

    bub     = '0;
    nop     = mk(1, 4'b0000, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0);
    e_add   = mk(1, 4'b0100, 0,  0, 0, 1, 0, 0, 0, 0, 0, 0);
    e_ori   = mk(1, 4'b0001, 0,  0, 0, 1, 1, 0, 2, 0, 0, 0);
    e_sll   = mk(1, 4'b1000, 5,  0, 0, 1, 0, 0, 0, 0, 0, 0);
    e_lui   = mk(1, 4'b1000, 16, 0, 0, 1, 1, 0, 1, 0, 0, 0);
    e_lw    = mk(1, 4'b0100, 0,  0, 3, 1, 1, 0, 1, 0, 0, 0);
    e_sw    = mk(1, 4'b0100, 0,  0, 0, 0, 1, 1, 1, 0, 0, 0);
    e_sub   = mk(1, 4'b0101, 0,  0, 0, 1, 0, 0, 0, 0, 0, 0);
    e_slt   = mk(1, 4'b1100, 0,  0, 0, 1, 0, 0, 0, 0, 0, 0);
    e_ill   = mk(0, 4'b0000, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1);
    e_mult  = mk(1, 4'b0110, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0);
    e_multu = mk(1, 4'b0111, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0);
    e_mfhi  = mk(1, 4'b0000, 0,  0, 1, 1, 0, 0, 0, 0, 0, 0);
    e_mflo  = mk(1, 4'b0000, 0,  0, 2, 1, 0, 0, 0, 0, 0, 0);
`ifdef GPIO_EN
    e_srl0  = mk(1, 4'b0000, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0);
    e_sra0  = mk(1, 4'b0000, 0,  0, 0, 1, 0, 0, 0, 0, 1, 0);
`else
    e_srl0  = mk(1, 4'b1001, 0,  0, 0, 1, 0, 0, 0, 0, 0, 0);
    e_sra0  = mk(1, 4'b1010, 0,  0, 0, 1, 0, 0, 0, 0, 0, 0);
`endif

    //   name           rst v  instr         st fl expected  stall
    step("reset0",      1, 0, 32'h00000000, 0, 0, bub,     0);
    step("reset1",      1, 0, 32'h00000000, 0, 0, bub,     0);
    // basic decode
    step("add",         0, 1, 32'h00221820, 0, 0, e_add,   0);
    step("ori",         0, 1, 32'h34220005, 0, 0, e_ori,   0);
    step("not_valid",   0, 0, 32'h00221820, 0, 0, bub,     0);
    step("nop",         0, 1, 32'h00000000, 0, 0, nop,     0);
    step("sll5",        0, 1, 32'h00021140, 0, 0, e_sll,   0);
    step("lui",         0, 1, 32'h3C011234, 0, 0, e_lui,   0);
    step("lw",          0, 1, 32'h8C220004, 0, 0, e_lw,    0);
    step("sw",          0, 1, 32'hAC220004, 0, 0, e_sw,    0);
    step("sub",         0, 1, 32'h00221822, 0, 0, e_sub,   0);
    step("slt",         0, 1, 32'h0022182A, 0, 0, e_slt,   0);
    step("srl0",        0, 1, 32'h00011802, 0, 0, e_srl0,  0);
    step("sra0",        0, 1, 32'h00011803, 0, 0, e_sra0,  0);
    // illegal encodings pulse for one cycle
    step("ill_op",      0, 1, 32'hFC000000, 0, 0, e_ill,   0);
    step("after_ill",   0, 0, 32'h00000000, 0, 0, bub,     0);
    step("ill_funct",   0, 1, 32'h0000003F, 0, 0, e_ill,   0);
    // mult then mfhi back-to-back: four interlock bubbles
    step("mult",        0, 1, 32'h00220018, 0, 0, e_mult,  0);
    step("mfhi_il1",    0, 1, 32'h00001810, 0, 0, bub,     1);
    step("mfhi_il2",    0, 1, 32'h00001810, 0, 0, bub,     1);
    step("mfhi_il3",    0, 1, 32'h00001810, 0, 0, bub,     1);
    step("mfhi_il4",    0, 1, 32'h00001810, 0, 0, bub,     1);
    step("mfhi_go",     0, 1, 32'h00001810, 0, 0, e_mfhi,  0);
    // flush beats stall_in
    step("flush_stall", 0, 1, 32'h00221820, 1, 1, bub,     1);
    step("nop2",        0, 1, 32'h00000000, 0, 0, nop,     0);
    // stall_in holds EX
    step("add2",        0, 1, 32'h00221820, 0, 0, e_add,   0);
    step("hold_add",    0, 1, 32'h34220005, 1, 0, e_add,   1);
    step("ori2",        0, 1, 32'h34220005, 0, 0, e_ori,   0);
    // stall-held mult loads busy_cnt only once
    step("mult2",       0, 1, 32'h00220018, 0, 0, e_mult,  0);
    step("hold_mult1",  0, 1, 32'h00221820, 1, 0, e_mult,  1);
    step("hold_mult2",  0, 1, 32'h00221820, 1, 0, e_mult,  1);
    step("mflo_il1",    0, 1, 32'h00001812, 0, 0, bub,     1);
    step("mflo_il2",    0, 1, 32'h00001812, 0, 0, bub,     1);
    step("mflo_go",     0, 1, 32'h00001812, 0, 0, e_mflo,  0);
    // flushed mult leaves HI/LO free
    step("mult_flush",  0, 1, 32'h00220018, 0, 1, bub,     0);
    step("mfhi_free",   0, 1, 32'h00001810, 0, 0, e_mfhi,  0);
    // reset in the busy window clears busy_cnt
    step("mult3",       0, 1, 32'h00220018, 0, 0, e_mult,  0);
    step("add3",        0, 1, 32'h00221820, 0, 0, e_add,   0);
    step("rst_pulse",   1, 0, 32'h00000000, 0, 0, bub,     0);
    step("mfhi_postrst",0, 1, 32'h00001810, 0, 0, e_mfhi,  0);
    // illegal held by stall_in drops its flag after one cycle
    step("ill_op2",     0, 1, 32'hFC000000, 0, 0, e_ill,   0);
    step("hold_ill",    0, 1, 32'h00221820, 1, 0, bub,     1);
    step("multu",       0, 1, 32'h00220019, 0, 0, e_multu, 0);
    step("multu_il",    0, 1, 32'h00220018, 0, 0, bub,     1);
    step("idle",        0, 0, 32'h00000000, 0, 0, bub,     0);
    step("idle_tail",   0, 0, 32'h00000000, 0, 0, bub,     0);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the stimulus process ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, required completion before 100000");
    $fatal(1, "timeout");
  end

endmodule
